// File: rtl/if_icache_pkg.sv
// if_icache_pkg: shared fetch-stage types, widths and cache state encodings
package if_icache_pkg;
  localparam int XlenDefault = 32;
  localparam int ICacheIndexBits = 6;
  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;
  localparam logic RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  typedef enum logic [1:0] {
    ICIdle  = 2'b00,
    ICMiss  = 2'b01,
    ICDrain = 2'b10
  } ic_state_t;
endpackage

// File: rtl/if_icache_if.sv
// if_icache_if: PC-stage, memory-controller and IF/ID signals of the fetch cache
interface if_icache_if import if_icache_pkg::*; #(parameter int XLEN = XlenDefault);
  logic            fetch_req;
  logic [XLEN-1:0] fetch_pc;
  logic            stall;
  logic            flush;
  logic            fence;
  logic [XLEN-1:0] mem_pc;
  logic            mem_req;
  logic            mem_pc_done;
  logic [XLEN-1:0] mem_pc_num;
  logic [XLEN-1:0] mem_inst;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic            inst_valid;
  logic            if_stall_req;
  modport master (
    output fetch_req, fetch_pc, stall, flush, fence, mem_pc_done, mem_pc_num, mem_inst,
    input  mem_pc, mem_req, inst, pc, inst_valid, if_stall_req
  );
  modport slave (
    input  fetch_req, fetch_pc, stall, flush, fence, mem_pc_done, mem_pc_num, mem_inst,
    output mem_pc, mem_req, inst, pc, inst_valid, if_stall_req
  );
endinterface

// File: rtl/if_icache_array.sv
// icache_array: direct-mapped tag/data storage with per-line valid bits and invalidate-all
module icache_array import if_icache_pkg::*; #(
  parameter int INDEX_BITS = ICacheIndexBits,
  parameter int TAG_BITS   = 24,
  parameter int XLEN       = XlenDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [XLEN-1:0]       rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  inval_all
);
  localparam int Lines = 1 << INDEX_BITS;
  logic [TAG_BITS-1:0] tags [Lines];
  logic [XLEN-1:0]     data [Lines];
  logic [Lines-1:0]    valid;
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];
  assign rd_valid = valid[rd_index];
  // line contents need no reset; the valid bits gate every read
  always_ff @(posedge clk)
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  // invalidate-all beats a same-cycle fill so a deferred fence also drops the new line
  always_ff @(posedge clk)
    if (rst == RstEnable || inval_all) valid <= '0;
    else if (wr_en) valid[wr_index] <= 1'b1;
endmodule

// File: rtl/if_icache.sv
// if_icache: instruction fetch stage with a direct-mapped one-word-per-line cache
module if_icache import if_icache_pkg::*; #(
  parameter int INDEX_BITS = ICacheIndexBits,
  parameter int XLEN       = XlenDefault
) (
  input logic clk,
  input logic rst,
  if_icache_if.slave bus
);
  localparam int TagBits = XLEN - INDEX_BITS - 2;
  ic_state_t state;
  logic [XLEN-1:0] miss_pc, held_inst, held_pc;
  logic held_valid, fence_pend;
  logic [TagBits-1:0] rd_tag;
  logic [XLEN-1:0] rd_data;
  logic rd_valid, hit, done_match, fill, inval_all;
  assign hit        = rd_valid && rd_tag == bus.fetch_pc[XLEN-1:INDEX_BITS+2] && !bus.fence;
  assign done_match = bus.mem_pc_done && bus.mem_pc_num == miss_pc;
  assign fill       = (state == ICMiss && done_match) || (state == ICDrain && bus.mem_pc_done);
  assign inval_all  = (state == ICIdle && bus.fence) || (fill && (fence_pend || bus.fence));
  icache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TagBits), .XLEN(XLEN)) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (bus.fetch_pc[INDEX_BITS+1:2]),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (fill),
    .wr_index (bus.mem_pc_num[INDEX_BITS+1:2]),
    .wr_tag   (bus.mem_pc_num[XLEN-1:INDEX_BITS+2]),
    .wr_data  (bus.mem_inst),
    .inval_all(inval_all)
  );
  // fetch FSM: lookup in idle, wait for the fill in miss, swallow a flushed fill in drain
  always_ff @(posedge clk)
    if (rst == RstEnable) begin
      state             <= ICIdle;
      bus.inst          <= ZeroWord;
      bus.pc            <= ZeroWord;
      bus.inst_valid    <= 1'b0;
      bus.mem_req       <= 1'b0;
      bus.mem_pc        <= ZeroWord;
      bus.if_stall_req  <= 1'b0;
      miss_pc           <= ZeroWord;
      held_inst         <= ZeroWord;
      held_pc           <= ZeroWord;
      held_valid        <= 1'b0;
      fence_pend        <= 1'b0;
    end else begin
      fence_pend <= state != ICIdle && !fill && (fence_pend || bus.fence);
      case (state)
        ICIdle:
          if (bus.flush) begin
            bus.inst_valid   <= 1'b0;
            bus.if_stall_req <= 1'b0;
            held_valid       <= 1'b0;
          end else if (!bus.stall) begin
            if (held_valid) begin
              bus.inst         <= held_inst;
              bus.pc           <= held_pc;
              bus.inst_valid   <= 1'b1;
              bus.if_stall_req <= 1'b0;
              held_valid       <= 1'b0;
            end else if (bus.fetch_req && hit) begin
              bus.inst       <= rd_data;
              bus.pc         <= bus.fetch_pc;
              bus.inst_valid <= 1'b1;
            end else if (bus.fetch_req) begin
              miss_pc          <= bus.fetch_pc;
              bus.mem_req      <= 1'b1;
              bus.mem_pc       <= bus.fetch_pc;
              bus.if_stall_req <= 1'b1;
              bus.inst_valid   <= 1'b0;
              state            <= ICMiss;
            end else bus.inst_valid <= 1'b0;
          end
        ICMiss:
          if (done_match) begin
            bus.mem_req <= 1'b0;
            state       <= ICIdle;
            if (bus.flush) bus.if_stall_req <= 1'b0;
            else if (bus.stall) begin
              held_inst  <= bus.mem_inst;
              held_pc    <= miss_pc;
              held_valid <= 1'b1;
            end else begin
              bus.inst         <= bus.mem_inst;
              bus.pc           <= miss_pc;
              bus.inst_valid   <= 1'b1;
              bus.if_stall_req <= 1'b0;
            end
          end else if (bus.flush) state <= ICDrain;
        ICDrain:
          if (bus.mem_pc_done) begin
            bus.mem_req      <= 1'b0;
            bus.if_stall_req <= 1'b0;
            state            <= ICIdle;
          end
        default: state <= ICIdle;
      endcase
    end
endmodule

// File: tb/tb_if_icache.sv
// tb_if_icache: directed stimulus with a scoreboard-checked instruction stream
module tb_if_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;
  if_icache_if bus();
  if_icache dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst"}, bus.inst, 0);
    chk({tag, "_pc"}, bus.pc, 0);
    chk({tag, "_inst_valid"}, bus.inst_valid, 0);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_pc"}, bus.mem_pc, 0);
    chk({tag, "_if_stall_req"}, bus.if_stall_req, 0);
  endtask

  task automatic mem_done(input logic [31:0] a, input logic [31:0] d);
    bus.mem_pc_done = 1'b1;
    bus.mem_pc_num  = a;
    bus.mem_inst    = d;
    step();
    bus.mem_pc_done = 1'b0;
  endtask

  task automatic miss_start(input logic [31:0] a);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = a;
    step();
    bus.fetch_req = 1'b0;
    chk("miss_mem_req", bus.mem_req, 1);
    chk("miss_mem_pc", bus.mem_pc, a);
    chk("miss_if_stall_req", bus.if_stall_req, 1);
    chk("miss_inst_valid", bus.inst_valid, 0);
  endtask

  task automatic miss_finish(input logic [31:0] a, input logic [31:0] d);
    sb.push_back({a, d});
    mem_done(a, d);
    chk("fill_mem_req", bus.mem_req, 0);
    chk("fill_if_stall_req", bus.if_stall_req, 0);
    chk("fill_inst_valid", bus.inst_valid, 1);
    step();
  endtask

  always @(negedge clk)
    if (!rst && bus.inst_valid && !bus.stall) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst got pc %08h inst %08h want no output", bus.pc, bus.inst);
      end else begin
        mon_exp = sb.pop_front();
        if ({bus.pc, bus.inst} !== mon_exp) begin
          errors++;
          $display("FAIL inst_stream got pc %08h inst %08h want pc %08h inst %08h",
                   bus.pc, bus.inst, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.fetch_req = 1'b0; bus.fetch_pc = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.fence = 1'b0; bus.mem_pc_done = 1'b0; bus.mem_pc_num = '0; bus.mem_inst = '0;
    repeat (2) step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    miss_start(32'h0);
    repeat (4) begin
      step();
      chk("cold_mem_req_hold", bus.mem_req, 1);
    end
    miss_finish(32'h0, 32'h0000_0013);
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0;
    sb.push_back({32'h0, 32'h0000_0013});
    sb.push_back({32'h0, 32'h0000_0013});
    repeat (2) begin
      step();
      chk("hit_mem_req", bus.mem_req, 0);
      chk("hit_if_stall_req", bus.if_stall_req, 0);
      chk("hit_inst", bus.inst, 32'h0000_0013);
    end
    bus.fetch_req = 1'b0;
    step();
    miss_start(32'h100);
    step();
    mem_done(32'h200, 32'hBAD0_BAD0);
    chk("stray_done_mem_req", bus.mem_req, 1);
    chk("stray_done_if_stall_req", bus.if_stall_req, 1);
    miss_finish(32'h100, 32'hDEAD_BEEF);
    miss_start(32'h0);
    step();
    miss_finish(32'h0, 32'h0000_0013);
    miss_start(32'h40);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("drain_mem_req", bus.mem_req, 1);
    chk("drain_if_stall_req", bus.if_stall_req, 1);
    chk("drain_inst_valid", bus.inst_valid, 0);
    step();
    mem_done(32'h40, 32'h1234_5678);
    chk("drain_done_inst_valid", bus.inst_valid, 0);
    chk("drain_done_mem_req", bus.mem_req, 0);
    chk("drain_done_if_stall_req", bus.if_stall_req, 0);
    step();
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h40;
    sb.push_back({32'h40, 32'h1234_5678});
    step();
    chk("drain_refetch_hit_mem_req", bus.mem_req, 0);
    bus.fetch_pc = 32'h0;
    bus.stall = 1'b1;
    repeat (3) begin
      step();
      chk("stall_inst", bus.inst, 32'h1234_5678);
      chk("stall_pc", bus.pc, 32'h40);
      chk("stall_inst_valid", bus.inst_valid, 1);
    end
    bus.stall = 1'b0; bus.fetch_req = 1'b0;
    step();
    miss_start(32'h80);
    bus.stall = 1'b1;
    step();
    mem_done(32'h80, 32'hCAFE_0001);
    chk("parked_inst_valid", bus.inst_valid, 0);
    chk("parked_mem_req", bus.mem_req, 0);
    step();
    chk("parked_hold_inst_valid", bus.inst_valid, 0);
    sb.push_back({32'h80, 32'hCAFE_0001});
    bus.stall = 1'b0;
    step();
    chk("unpark_inst_valid", bus.inst_valid, 1);
    chk("unpark_inst", bus.inst, 32'hCAFE_0001);
    chk("unpark_pc", bus.pc, 32'h80);
    step();
    miss_start(32'h4);
    miss_finish(32'h4, 32'h0040_0093);
    bus.fence = 1'b1;
    step();
    bus.fence = 1'b0;
    miss_start(32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("mid_miss_reset");
    mem_done(32'h0, 32'h0000_0013);
    chk("late_done_inst_valid", bus.inst_valid, 0);
    chk("late_done_mem_req", bus.mem_req, 0);
    chk("late_done_if_stall_req", bus.if_stall_req, 0);
    miss_start(32'h0);
    bus.fence = 1'b1;
    step();
    bus.fence = 1'b0;
    step();
    miss_finish(32'h0, 32'h0000_0013);
    miss_start(32'h0);
    miss_finish(32'h0, 32'h0000_0013);
    repeat (2) step();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
